logic_net_sig_capture: RTL and testbench
========================================

# logic_net_sig_capture

Response-compaction stage placed directly downstream of `logic_net`: samples its `OUT` bit once per enabled cycle over a programmable window and folds the samples into a multiple-input signature register (MISR) and a ones counter. At window end it presents signature and count on a valid/ready handshake. Used as the capture side of the netlist's timing/functional test harness; one window per `Start`.

## Interface

Parameters:
- `SIG_W`, 16, signature width (≥ 2).
- `CNT_W`, 16, window-length and ones-count width.
- `POLY`, 16'h1021, MISR feedback polynomial, `SIG_W` bits.
- `SEED`, 16'h0000, signature value loaded at window start, `SIG_W` bits.

Ports:
- `Clk`  in  1  single clock, all state on rising edge.
- `Rst`  in  1  reset, asynchronous and active-high.
- `Start`  in  1  begin a window; honoured in IDLE only.
- `Win_len`  in  CNT_W  number of samples in the window; sampled with `Start`.
- `En`  in  1  sample enable; a RUN cycle with `En=0` is a stall.
- `Din`  in  1  data bit, connected to `logic_net.OUT`.
- `Sig_rdy`  in  1  consumer ready.
- `Busy`  out  1  high whenever state ≠ IDLE.
- `Sig_vld`  out  1  result valid, high only in HOLD.
- `Sig`  out  SIG_W  signature.
- `Ones_cnt`  out  CNT_W  number of `Din=1` samples in the window.

## Operation

- States: IDLE, RUN, HOLD (registered, encoded in shared package).
- IDLE: `Start=1` loads `Sig←SEED`, `Ones_cnt←0`, `remain←Win_len`; next state RUN if `Win_len≠0`, else HOLD.
- RUN, `En=1`: sample `Din`; `Sig ← ({Sig[SIG_W-2:0],1'b0} ^ (Sig[SIG_W-1] ? POLY : 0)) ^ {{SIG_W-1{0}},Din}`; `Ones_cnt += Din`; `remain -= 1`; if `remain==1` before decrement, next state HOLD.
- RUN, `En=0`: all registers hold.
- HOLD: `Sig`, `Ones_cnt` frozen; `Sig_vld=1`. `Sig_vld && Sig_rdy` → IDLE next cycle.
- `Start` in RUN or HOLD: ignored, no effect on window.
- No overflow possible: `Ones_cnt ≤ Win_len ≤ 2^CNT_W−1`.
- `Sig`/`Ones_cnt` show running values during RUN; contractually valid only while `Sig_vld=1`. In IDLE they retain the last result.
- Reset (any state, mid-window included): state IDLE, `Sig=0`, `Ones_cnt=0`, `remain=0`, `Busy=0`, `Sig_vld=0`; partial window discarded.

## Timing

- `Start` accepted at edge k; first sample taken at edge k+1 (`Din` of cycle k+1).
- `Win_len=N`, no stalls: samples at edges k+1…k+N; `Sig_vld` high from cycle after edge k+N. Each `En=0` cycle adds one cycle.
- `Win_len=0`: `Sig_vld` high the cycle after `Start`, `Sig=SEED`, `Ones_cnt=0`.
- `Sig_vld` held until handshake; drops the cycle after `Sig_rdy` sampled high; `Start` can be accepted that following cycle (minimum one IDLE cycle between windows).
- `Busy` rises the cycle after `Start`, falls with `Sig_vld`.
- All outputs registered; no combinational path from inputs to outputs.
- Upstream aligns stimulus for `logic_net`'s two-flop latency; this block adds none beyond the one-cycle sample register.

## Structure

- Shared package `logic_net_pkg`: state enum (IDLE/RUN/HOLD), default `POLY`/`SEED` constants, `SIG_W`/`CNT_W` defaults.
- Sub-module `misr_step`: purely combinational next-signature function (`Sig`, `Din`, `POLY` → next `Sig`), reused by the bench's reference model.
- Top holds FSM, `remain` down-counter, ones counter, output registers.

## Test plan

- Defaults, `Win_len=3`, `Din`=1,0,1, `En=1` → `Sig=16'h0005`, `Ones_cnt=2`, `Sig_vld` high 4 cycles after `Start`.
- `SEED=16'h8000`, `Win_len=1`, `Din=0` → `Sig=16'h1021` (feedback on MSB), `Ones_cnt=0`.
- `Win_len=3`, `Din`=1,1,1 with `En` low for 2 cycles mid-window → `Sig=16'h0007`, `Ones_cnt=3`, `Sig_vld` 2 cycles later than unstalled.
- `Win_len=0` → `Sig_vld=1` next cycle, `Sig=SEED`, `Ones_cnt=0`; `Sig_rdy` held low 5 cycles → outputs stable; `Start` pulses during RUN/HOLD ignored.
- `Rst` asserted mid-RUN (after 2 of 5 samples) → immediate `Busy=0`, `Sig=0`, `Ones_cnt=0`, `Sig_vld=0`; new `Start` after release produces a clean window result.
- 1000 random windows (random `Win_len`, `En`, `Din`, `Sig_rdy`) → `Sig`/`Ones_cnt` match model built on `misr_step`; `Sig_vld` never drops without handshake.

Source files
------------

// File: rtl/logic_net_sig_capture_pkg.sv
// Shared definitions for the logic_net response-capture stage:
// FSM state encoding and default signature parameters.
package logic_net_pkg;

  localparam int          SIG_W_DEF = 16;
  localparam int          CNT_W_DEF = 16;
  localparam logic [15:0] POLY_DEF  = 16'h1021;
  localparam logic [15:0] SEED_DEF  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/logic_net_sig_capture_if.sv
// Control, sample and result-handshake signals of the capture stage.
// master = stimulus/consumer side, slave = the capture block.
interface logic_net_sig_capture_if #(
  parameter int SIG_W = 16,
  parameter int CNT_W = 16
);
  logic             Start;
  logic [CNT_W-1:0] Win_len;
  logic             En;
  logic             Din;
  logic             Sig_rdy;
  logic             Busy;
  logic             Sig_vld;
  logic [SIG_W-1:0] Sig;
  logic [CNT_W-1:0] Ones_cnt;

  modport master (
    output Start, Win_len, En, Din, Sig_rdy,
    input  Busy, Sig_vld, Sig, Ones_cnt
  );

  modport slave (
    input  Start, Win_len, En, Din, Sig_rdy,
    output Busy, Sig_vld, Sig, Ones_cnt
  );
endinterface

// File: rtl/logic_net_sig_capture_misr_step.sv
// One MISR clock: shift left, fold the polynomial in when the MSB falls out,
// then XOR the new sample into bit 0. Purely combinational.
module misr_step #(
  parameter int SIG_W = 16
) (
  input  logic [SIG_W-1:0] sig,
  input  logic             din,
  input  logic [SIG_W-1:0] poly,
  output logic [SIG_W-1:0] sig_next
);

  assign sig_next = ({sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? poly : '0))
                  ^ {{(SIG_W-1){1'b0}}, din};

endmodule

// File: rtl/logic_net_sig_capture.sv
// Signature capture for logic_net.OUT: folds Win_len enabled samples into a
// MISR and a ones counter, then offers the result on a valid/ready handshake.
module logic_net_sig_capture
  import logic_net_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter int               CNT_W = CNT_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEF),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEF)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  logic_net_sig_capture_if.slave  bus
);

  state_t           state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d, sig_step;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] remain_q, remain_d;
  logic             busy_q, busy_d;
  logic             vld_q, vld_d;

  misr_step #(.SIG_W(SIG_W)) u_misr_step (
    .sig      (sig_q),
    .din      (bus.Din),
    .poly     (POLY),
    .sig_next (sig_step)
  );

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    ones_d   = ones_q;
    remain_d = remain_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          sig_d    = SEED;
          ones_d   = '0;
          remain_d = bus.Win_len;
          state_d  = (bus.Win_len != '0) ? ST_RUN : ST_HOLD;
        end
      end
      ST_RUN: begin
        // En=0 is a stall: nothing moves, including the remaining count.
        if (bus.En) begin
          sig_d    = sig_step;
          ones_d   = ones_q + CNT_W'(bus.Din);
          remain_d = remain_q - CNT_W'(1);
          if (remain_q == CNT_W'(1)) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.Sig_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags decoded from the next state so they leave a flop directly.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    vld_d  = (state_d == ST_HOLD);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      sig_q    <= '0;
      ones_q   <= '0;
      remain_q <= '0;
      busy_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      ones_q   <= ones_d;
      remain_q <= remain_d;
      busy_q   <= busy_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.Busy     = busy_q;
  assign bus.Sig_vld  = vld_q;
  assign bus.Sig      = sig_q;
  assign bus.Ones_cnt = ones_q;

endmodule

// File: tb/tb_logic_net_sig_capture.sv
// Self-checking bench for logic_net_sig_capture: vector table, hand-written
// corner sequences and random windows against a scoreboard.
module tb_logic_net_sig_capture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_net_sig_capture_if #(.SIG_W(16), .CNT_W(16)) bus_a ();
  logic_net_sig_capture_if #(.SIG_W(16), .CNT_W(16)) bus_b ();

  logic_net_sig_capture dut_a (.Clk(clk), .Rst(rst), .bus(bus_a));
  logic_net_sig_capture #(.SEED(16'h8000)) dut_b (.Clk(clk), .Rst(rst), .bus(bus_b));

  logic [15:0] ms_sig;
  logic        ms_din;
  logic [15:0] ms_next;
  misr_step #(.SIG_W(16)) u_ms (.sig(ms_sig), .din(ms_din), .poly(16'h1021), .sig_next(ms_next));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic [15:0] ones;
  } res_t;
  res_t sb[$];

  typedef struct {
    int          len;
    logic [31:0] dbits;
    int          stall_at;
    int          stall_n;
    int          rdy_wait;
    bit          noise;
    logic [15:0] exp_sig;
    logic [15:0] exp_ones;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s, input logic d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    r[0] = r[0] ^ d;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic recover();
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
    sb.delete();
  endtask

  // One full window on dut_a. Table mode uses dbits/stalls and pushes the
  // table's expectation; random mode picks En/Din/Start noise per cycle and
  // pushes the model's result.
  task automatic run_window(input int len, input logic [31:0] dbits, input int stall_at,
                            input int stall_n, input int rdy_wait, input bit noise,
                            input bit rnd, input res_t exp_tab);
    logic [15:0] m_sig;
    logic [15:0] m_ones;
    logic [15:0] h_sig;
    logic [15:0] h_ones;
    bit          ok;
    bit          en;
    logic        d;
    int          s;
    int          stalls;
    res_t        exp;

    m_sig = 16'h0000;
    m_ones = 16'h0000;
    bus_a.Start = 1'b1;
    bus_a.Win_len = 16'(len);
    bus_a.En = 1'b0;
    bus_a.Sig_rdy = 1'b0;
    if (!rnd) sb.push_back(exp_tab);
    tick();
    ok = (bus_a.Busy === 1'b1) && (bus_a.Sig_vld === (len == 0));
    bus_a.Start = 1'b0;
    s = 0;
    stalls = 0;
    while (s < len) begin
      if (rnd) begin
        en = ($urandom_range(0, 3) != 0);
        bus_a.Start = 1'($urandom_range(0, 1));
        bus_a.Win_len = 16'($urandom);
      end else begin
        en = !(s == stall_at && stalls < stall_n);
        bus_a.Start = noise;
        bus_a.Win_len = 16'd7;
      end
      bus_a.En = en;
      if (en) begin
        d = rnd ? 1'($urandom_range(0, 1)) : dbits[s];
        bus_a.Din = d;
        m_sig = ref_step(m_sig, d);
        m_ones = m_ones + 16'(d);
        s++;
      end else begin
        bus_a.Din = 1'($urandom_range(0, 1));
        stalls++;
      end
      tick();
      if (s < len) ok = ok && (bus_a.Busy === 1'b1) && (bus_a.Sig_vld === 1'b0);
      else         ok = ok && (bus_a.Busy === 1'b1) && (bus_a.Sig_vld === 1'b1);
    end
    if (rnd) begin
      exp.sig = m_sig;
      exp.ones = m_ones;
      sb.push_back(exp);
    end
    check("timing", 64'(ok), 64'd1);
    bus_a.En = 1'b0;
    bus_a.Start = 1'b0;
    for (int t = 0; t < 64 && bus_a.Sig_vld !== 1'b1; t++) tick();
    if (bus_a.Sig_vld !== 1'b1) begin
      check("vld_timeout", 64'(bus_a.Sig_vld), 64'd1);
      recover();
      return;
    end
    h_sig = bus_a.Sig;
    h_ones = bus_a.Ones_cnt;
    ok = 1'b1;
    for (int w = 0; w < rdy_wait; w++) begin
      bus_a.Start = rnd ? 1'($urandom_range(0, 1)) : noise;
      bus_a.Win_len = 16'd9;
      tick();
      ok = ok && (bus_a.Sig_vld === 1'b1) && (bus_a.Busy === 1'b1)
              && (bus_a.Sig === h_sig) && (bus_a.Ones_cnt === h_ones);
    end
    if (rdy_wait > 0) check("hold_stable", 64'(ok), 64'd1);
    exp = sb.pop_front();
    check("sig", 64'(bus_a.Sig), 64'(exp.sig));
    check("ones", 64'(bus_a.Ones_cnt), 64'(exp.ones));
    $display("[TB] window len=%0d stalls=%0d sig=%04h ones=%0d exp_sig=%04h exp_ones=%0d",
             len, stalls, bus_a.Sig, bus_a.Ones_cnt, exp.sig, exp.ones);
    bus_a.Sig_rdy = 1'b1;
    tick();
    check("release", {62'd0, bus_a.Sig_vld, bus_a.Busy}, 64'd0);
    bus_a.Sig_rdy = 1'b0;
    bus_a.Start = 1'b0;
  endtask

  initial begin
    res_t e;
    vecs[0] = '{3,  32'b101,     -1, 0, 0, 1'b0, 16'h0005, 16'd2};
    vecs[1] = '{3,  32'b111,      1, 2, 1, 1'b0, 16'h0007, 16'd3};
    vecs[2] = '{0,  32'h0,       -1, 0, 5, 1'b1, 16'h0000, 16'd0};
    vecs[3] = '{1,  32'h1,       -1, 0, 0, 1'b0, 16'h0001, 16'd1};
    vecs[4] = '{16, 32'hFFFF,    -1, 0, 2, 1'b1, 16'hFFFF, 16'd16};
    vecs[5] = '{17, 32'h1FFFF,    3, 1, 0, 1'b0, 16'hEFDE, 16'd17};
    vecs[6] = '{4,  32'b0110,    -1, 0, 1, 1'b0, 16'h0006, 16'd2};

    bus_a.Start = 1'b0; bus_a.Win_len = '0; bus_a.En = 1'b0; bus_a.Din = 1'b0; bus_a.Sig_rdy = 1'b0;
    bus_b.Start = 1'b0; bus_b.Win_len = '0; bus_b.En = 1'b0; bus_b.Din = 1'b0; bus_b.Sig_rdy = 1'b0;
    ms_sig = '0; ms_din = 1'b0;

    tick();
    tick();
    check("rst_busy", 64'(bus_a.Busy), 64'd0);
    check("rst_vld", 64'(bus_a.Sig_vld), 64'd0);
    check("rst_sig", 64'(bus_a.Sig), 64'd0);
    check("rst_ones", 64'(bus_a.Ones_cnt), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      e.sig = vecs[i].exp_sig;
      e.ones = vecs[i].exp_ones;
      run_window(vecs[i].len, vecs[i].dbits, vecs[i].stall_at, vecs[i].stall_n,
                 vecs[i].rdy_wait, vecs[i].noise, 1'b0, e);
    end

    // Seed with MSB set: the first shift must fold in the polynomial.
    bus_b.Start = 1'b1; bus_b.Win_len = 16'd1;
    tick();
    bus_b.Start = 1'b0; bus_b.En = 1'b1; bus_b.Din = 1'b0;
    tick();
    bus_b.En = 1'b0;
    check("seed_vld", 64'(bus_b.Sig_vld), 64'd1);
    check("seed_sig", 64'(bus_b.Sig), 64'h1021);
    check("seed_ones", 64'(bus_b.Ones_cnt), 64'd0);
    $display("[TB] seed window sig=%04h ones=%0d", bus_b.Sig, bus_b.Ones_cnt);
    bus_b.Sig_rdy = 1'b1;
    tick();
    bus_b.Sig_rdy = 1'b0;
    check("seed_release", 64'(bus_b.Sig_vld), 64'd0);

    // Reset after two of five samples discards the partial window.
    bus_a.Start = 1'b1; bus_a.Win_len = 16'd5;
    tick();
    bus_a.Start = 1'b0; bus_a.En = 1'b1; bus_a.Din = 1'b1;
    tick();
    tick();
    bus_a.En = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst", {bus_a.Busy, bus_a.Sig_vld, bus_a.Sig, bus_a.Ones_cnt}, 64'd0);
    $display("[TB] mid-window reset busy=%0b vld=%0b sig=%04h ones=%0d",
             bus_a.Busy, bus_a.Sig_vld, bus_a.Sig, bus_a.Ones_cnt);
    tick();
    rst = 1'b0;
    tick();
    e.sig = 16'h0005;
    e.ones = 16'd2;
    run_window(3, 32'b101, -1, 0, 0, 1'b0, 1'b0, e);

    for (int i = 0; i < 32; i++) begin
      ms_sig = 16'($urandom);
      ms_din = 1'($urandom_range(0, 1));
      #1;
      check("misr_step", 64'(ms_next), 64'(ref_step(ms_sig, ms_din)));
    end

    for (int i = 0; i < 1000; i++) begin
      e = '0;
      run_window($urandom_range(0, 24), 32'h0, -1, 0, $urandom_range(0, 3), 1'b0, 1'b1, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
